// File: rtl/cpu_lsu_bus.sv
// cpu_lsu_bus: load/store unit that turns one CPU memory op into a single-beat bus access.
// Define LSU_TIMEOUT_EN to abort accesses that wait more than TIMEOUT_CYCLES for Bus_ready.
module cpu_lsu_bus #(
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          stall,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          Bus_req,
  output logic [AW-1:0] Bus_addr,
  output logic          Bus_wen,
  output logic [31:0]   Bus_wdata,
  output logic [3:0]    Bus_be,
  input  logic          Bus_ready,
  input  logic [31:0]   Bus_rdata
);

  // state  | meaning
  // IDLE   | waiting for req_valid; stall mirrors req_valid
  // ACCESS | bus access in flight; CPU stalled
  // DONE   | one-cycle response strobe; CPU released
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;

  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        we_q;

  logic        req_ok;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic        timeout_hit;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYCLES));
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    req_ok        = 1'b0;
    req_be        = 4'b0000;
    req_wdata_rep = 32'd0;
    case (req_size)
      2'd0: begin
        req_ok        = 1'b1;
        req_be        = 4'b0001 << req_addr[1:0];
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_ok        = ~req_addr[0];
        req_be        = 4'b0011 << req_addr[1:0];
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        req_ok        = (req_addr[1:0] == 2'b00);
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
      end
      default: ;
    endcase
    if (!req_we) req_wdata_rep = 32'd0;
  end

  // Lane select and extension of the returned word, using the latched low address bits.
  always_comb begin
    ld_byte = Bus_rdata[7:0];
    case (addr_lo_q)
      2'd1:    ld_byte = Bus_rdata[15:8];
      2'd2:    ld_byte = Bus_rdata[23:16];
      2'd3:    ld_byte = Bus_rdata[31:24];
      default: ld_byte = Bus_rdata[7:0];
    endcase
    ld_half = addr_lo_q[1] ? Bus_rdata[31:16] : Bus_rdata[15:0];
    case (size_q)
      2'd0:    load_data = {{24{ld_byte[7] & ~unsigned_q}}, ld_byte};
      2'd1:    load_data = {{16{ld_half[15] & ~unsigned_q}}, ld_half};
      default: load_data = Bus_rdata;
    endcase
    if (we_q) load_data = 32'd0;
  end

  always_comb begin
    stall = 1'b0;
    if (!cpu_rst) begin
      case (state)
        IDLE:    stall = req_valid;
        ACCESS:  stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state      <= IDLE;
      addr_lo_q  <= 2'd0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'd0;
      Bus_req    <= 1'b0;
      Bus_addr   <= '0;
      Bus_wen    <= 1'b0;
      Bus_wdata  <= 32'd0;
      Bus_be     <= 4'b0000;
`ifdef LSU_TIMEOUT_EN
      wait_cnt   <= 8'd0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_lo_q  <= req_addr[1:0];
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            we_q       <= req_we;
`ifdef LSU_TIMEOUT_EN
            wait_cnt   <= 8'd0;
`endif
            if (req_ok) begin
              state     <= ACCESS;
              Bus_req   <= 1'b1;
              Bus_addr  <= {req_addr[AW-1:2], 2'b00};
              Bus_wen   <= req_we;
              Bus_be    <= req_be;
              Bus_wdata <= req_wdata_rep;
            end else begin
              // Errored requests skip the bus entirely.
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end
          end
        end
        ACCESS: begin
          // A timeout takes priority over a Bus_ready arriving in the same cycle.
          if (timeout_hit || Bus_ready) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= timeout_hit;
            rsp_rdata <= timeout_hit ? 32'd0 : load_data;
            Bus_req   <= 1'b0;
            Bus_wen   <= 1'b0;
            Bus_be    <= 4'b0000;
          end
`ifdef LSU_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_lsu_bus.sv
// Randomized bench for cpu_lsu_bus: a cycle-level expectation schedule derived from
// byte-lane arithmetic, checked every cycle, plus literal pins on known transactions.
module tb_cpu_lsu_bus;
  localparam int TMO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        Bus_req, Bus_wen, Bus_ready;
  logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
  logic [3:0]  Bus_be;

  always #5 cpu_clk = ~cpu_clk;

  cpu_lsu_bus #(.AW(32), .TIMEOUT_CYCLES(TMO)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Bus_req(Bus_req), .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata),
    .Bus_be(Bus_be), .Bus_ready(Bus_ready), .Bus_rdata(Bus_rdata)
  );

  int total = 0;
  int bad = 0;

  bit          chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_rsp_valid = 1'b0, exp_bus_req = 1'b0;
  logic        exp_bus_wen = 1'b0, exp_rsp_err = 1'b0, exp_cleared = 1'b0;
  logic [31:0] exp_bus_addr = 0, exp_bus_wdata = 0, exp_rsp_rdata = 0;
  logic [3:0]  exp_bus_be = 0;

  int          stall_cnt = 0, last_stall = 0, bus_cyc = 0;
  logic [31:0] last_rdata = 0, last_addr = 0, last_wdata = 0;
  logic        last_err = 0, last_wen = 0;
  logic [3:0]  last_be = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: byte-lane arithmetic on (size, address).
  function automatic bit legal(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b0;
    return (a % (32'd1 << sz)) == 0;
  endfunction

  function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [31:0] a);
    int n = 1 << sz;
    int m = ((1 << n) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] wrep(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r = 0;
    int n = 1 << sz;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ldext(input logic [1:0] sz, input bit uns,
                                        input logic [31:0] a, input logic [31:0] w);
    int n = 1 << sz;
    int sh = 8 * int'(a % 4);
    logic [31:0] mask, v;
    if (sz == 2'd2) return w;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (w >> sh) & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge cpu_clk) begin
    if (chk_en) begin
      chk("stall", stall, exp_stall);
      chk("rsp_valid", rsp_valid, exp_rsp_valid);
      chk("bus_req", Bus_req, exp_bus_req);
      chk("rsp_rdata", rsp_rdata, exp_rsp_rdata);
      if (exp_bus_req) begin
        chk("bus_addr", Bus_addr, exp_bus_addr);
        chk("bus_be", Bus_be, exp_bus_be);
        chk("bus_wen", Bus_wen, exp_bus_wen);
        chk("bus_wdata", Bus_wdata, exp_bus_wdata);
      end else begin
        chk("bus_be_idle", Bus_be, 4'b0000);
        chk("bus_wen_idle", Bus_wen, 1'b0);
      end
      if (exp_rsp_valid) chk("rsp_err", rsp_err, exp_rsp_err);
      if (exp_cleared) begin
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_bus_addr", Bus_addr, 32'd0);
        chk("rst_bus_wdata", Bus_wdata, 32'd0);
      end
      if (stall === 1'b1) stall_cnt++;
      if (Bus_req === 1'b1) begin
        bus_cyc++;
        last_addr = Bus_addr; last_be = Bus_be; last_wen = Bus_wen; last_wdata = Bus_wdata;
      end
      if (rsp_valid === 1'b1) begin
        last_rdata = rsp_rdata; last_err = rsp_err;
        last_stall = stall_cnt; stall_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge cpu_clk); #1;
  endtask

  task automatic settle();
    @(negedge cpu_clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      req_valid = 1'b0;
      Bus_ready = 1'($urandom % 2); Bus_rdata = $urandom;
      exp_stall = 1'b0; exp_bus_req = 1'b0; exp_rsp_valid = 1'b0; exp_cleared = 1'b0;
    end
  endtask

  // One CPU op: acceptance cycle, `lat` ready-low ACCESS cycles, then DONE.
  task automatic run_req(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input int lat, input logic [31:0] word);
    bit ok, tmo;
    int last_k;
    ok = legal(sz, a);
    tmo = ok && TO_EN && (lat >= TMO);
    last_k = tmo ? TMO : lat;
    step();
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = d;
    Bus_ready = 1'($urandom % 2); Bus_rdata = $urandom;
    exp_stall = 1'b1; exp_rsp_valid = 1'b0; exp_bus_req = 1'b0; exp_cleared = 1'b0;
    if (ok) begin
      for (int k = 0; k <= last_k; k++) begin
        step();
        if (tmo) Bus_ready = (k == last_k) ? 1'($urandom % 2) : 1'b0;
        else Bus_ready = (k == last_k);
        Bus_rdata = Bus_ready ? word : $urandom;
        exp_stall = 1'b1; exp_bus_req = 1'b1;
        exp_bus_addr = a & ~32'd3; exp_bus_be = lanes(sz, a); exp_bus_wen = we;
        exp_bus_wdata = we ? wrep(sz, d) : 32'd0;
      end
    end
    step();
    // The CPU moves on during DONE; whatever it presents now must not be taken.
    req_valid = 1'($urandom % 2); req_we = 1'($urandom % 2); req_size = 2'($urandom % 4);
    req_addr = $urandom; req_wdata = $urandom;
    Bus_ready = 1'($urandom % 2); Bus_rdata = $urandom;
    exp_stall = 1'b0; exp_bus_req = 1'b0; exp_rsp_valid = 1'b1;
    exp_rsp_err = !ok || tmo;
    exp_rsp_rdata = (!ok || tmo || we) ? 32'd0 : ldext(sz, uns, a, word);
  endtask

  task automatic reset_mid_access();
    step();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h200; req_wdata = 32'd0; Bus_ready = 1'b0;
    exp_stall = 1'b1; exp_rsp_valid = 1'b0; exp_bus_req = 1'b0; exp_cleared = 1'b0;
    step();
    Bus_ready = 1'b0;
    exp_stall = 1'b1; exp_bus_req = 1'b1; exp_bus_addr = 32'h200; exp_bus_be = 4'hF;
    exp_bus_wen = 1'b0; exp_bus_wdata = 32'd0;
    step();
    cpu_rst = 1'b1; Bus_ready = 1'b1; Bus_rdata = 32'hCAFEF00D;
    exp_stall = 1'b0;
    step();
    cpu_rst = 1'b0; req_valid = 1'b0; Bus_ready = 1'b0;
    exp_stall = 1'b0; exp_bus_req = 1'b0; exp_rsp_valid = 1'b0;
    exp_rsp_rdata = 32'd0; exp_cleared = 1'b1;
    idle(2);
  endtask

  initial begin
    cpu_rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; Bus_ready = 1'b0; Bus_rdata = 32'd0;
    step();
    chk_en = 1'b1; exp_cleared = 1'b1;
    step();
    step();
    cpu_rst = 1'b0; req_valid = 1'b0;
    idle(2);

    stall_cnt = 0;
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 0, 32'hDEADBEEF);
    settle();
    chk("lw_rdata", last_rdata, 32'hDEADBEEF);
    chk("lw_err", last_err, 1'b0);
    chk("lw_stall_cycles", last_stall, 2);

    run_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 1, 32'h11111111);
    settle();
    chk("sb_addr", last_addr, 32'h100);
    chk("sb_be", last_be, 4'b1000);
    chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
    chk("sb_wen", last_wen, 1'b1);
    chk("sb_rdata", last_rdata, 32'd0);

    run_req(1'b0, 2'd0, 1'b0, 32'h102, 32'd0, 0, 32'h00800000);
    settle();
    chk("lb_rdata", last_rdata, 32'hFFFFFF80);
    run_req(1'b0, 2'd0, 1'b1, 32'h102, 32'd0, 2, 32'h00800000);
    settle();
    chk("lbu_rdata", last_rdata, 32'h00000080);

    idle(1);
    bus_cyc = 0; stall_cnt = 0;
    run_req(1'b0, 2'd1, 1'b0, 32'h101, 32'd0, 0, 32'h0);
    settle();
    chk("lh_mis_err", last_err, 1'b1);
    chk("lh_mis_busreq", bus_cyc, 0);
    chk("lh_mis_stall", last_stall, 1);

    idle(1);
    bus_cyc = 0; stall_cnt = 0;
    run_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 120, 32'h5A5A5A5A);
    settle();
`ifdef LSU_TIMEOUT_EN
    chk("tmo_err", last_err, 1'b1);
    chk("tmo_rdata", last_rdata, 32'd0);
    chk("tmo_access_cycles", bus_cyc, TMO + 1);
`else
    chk("hang_stall_cycles", last_stall, 122);
    chk("hang_rdata", last_rdata, 32'h5A5A5A5A);
`endif

    idle(1);
    reset_mid_access();
    run_req(1'b0, 2'd2, 1'b0, 32'h300, 32'd0, 1, 32'h12345678);
    settle();
    chk("post_rst_lw", last_rdata, 32'h12345678);
    chk("post_rst_err", last_err, 1'b0);

    for (int t = 0; t < 200; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          lat;
      sz = 2'($urandom % 4);
      a = $urandom;
      if (sz != 2'd3 && ($urandom % 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      lat = TO_EN ? int'($urandom % 7) : int'($urandom % 4);
      run_req(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, lat, $urandom);
      if (($urandom % 3) == 0) idle(int'($urandom % 3));
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
